// File: rtl/cram_pkg.sv
// Shared encodings for the CellularRAM page-mode controller: commands, FSM states,
// and the register-select codes placed on the top address bits for config writes.
package cram_pkg;

    localparam logic [1:0] CMD_READ  = 2'b00;
    localparam logic [1:0] CMD_WRITE = 2'b01;
    localparam logic [1:0] CMD_RCR   = 2'b10;
    localparam logic [1:0] CMD_BCR   = 2'b11;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ARD   = 3'd1;
    localparam logic [2:0] ST_PRD   = 3'd2;
    localparam logic [2:0] ST_AWR   = 3'd3;
    localparam logic [2:0] ST_RECOV = 3'd4;

    localparam logic [1:0] CR_SEL_RCR = 2'b00;
    localparam logic [1:0] CR_SEL_BCR = 2'b10;

    function automatic logic is_cfg_cmd(input logic [1:0] cmd);
        return cmd == CMD_RCR || cmd == CMD_BCR;
    endfunction

endpackage

// File: rtl/cram_timer.sv
// Loadable down-counter that times each CRAM access phase; saturates at zero.
// load wins over hold; hold freezes the count so a stalled read keeps its position.
module cram_timer #(
    parameter int W = 3
) (
    input  logic         Clock,
    input  logic         aReset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         hold,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge Clock or posedge aReset) begin
        if (aReset)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (!hold && cnt != '0)
            cnt <= cnt - W'(1);
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/cram_page_ctrl.sv
// CellularRAM controller: page-mode burst reads, async writes and RCR/BCR config writes.
// A zero-length read completes at once with err; reads pause at the sample point while rd_stall is high.
module cram_page_ctrl #(
    parameter int ADDR_W     = 23,
    parameter int DATA_W     = 16,
    parameter int PAGE_WORDS = 16,
    parameter int LEN_W      = 8,
    parameter int T_ASYNC    = 7,
    parameter int T_PAGE     = 2,
    parameter int T_WRITE    = 7,
    parameter int T_REC      = 1
) (
    input  logic              Clock,
    input  logic              aReset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_cmd,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LEN_W-1:0]  req_len,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_stall,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              done,
    output logic              err,
    output logic              busy,
    output logic [ADDR_W-1:0] cram_addr,
    output logic              cram_ce_n,
    output logic              cram_oe_n,
    output logic              cram_we_n,
    output logic              cram_cre,
    output logic [DATA_W-1:0] cram_dq_out,
    output logic              cram_dq_oe,
    input  logic [DATA_W-1:0] cram_dq_in
);

    import cram_pkg::*;

    localparam int PG_BITS = $clog2(PAGE_WORDS);
    localparam int T_MAX_A = (T_ASYNC > T_PAGE) ? T_ASYNC : T_PAGE;
    localparam int T_MAX_B = (T_WRITE > T_REC) ? T_WRITE : T_REC;
    localparam int T_MAX   = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;
    localparam int TMR_W   = $clog2(T_MAX) + 1;

    logic [2:0]        state, state_nxt;
    logic [1:0]        cmd_q;
    logic [LEN_W-1:0]  cnt_q;
    logic [DATA_W-1:0] wdata_q;

    logic              tmr_load, tmr_hold, tmr_zero;
    logic [TMR_W-1:0]  tmr_val;

    logic              accept, zero_len, rd_phase, capture, page_wrap, last_word;
    logic [ADDR_W-1:0] addr_inc, addr_start;

    assign accept    = req_valid && req_ready;
    assign zero_len  = (req_cmd == CMD_READ) && (req_len == '0);
    assign rd_phase  = (state == ST_ARD) || (state == ST_PRD);
    assign capture   = rd_phase && tmr_zero && !rd_stall;
    assign last_word = (cnt_q == LEN_W'(1));
    assign addr_inc  = cram_addr + ADDR_W'(1);
    assign page_wrap = (addr_inc[PG_BITS-1:0] == '0);
    assign tmr_hold  = rd_phase && tmr_zero && rd_stall;

    // Config writes steer the register select onto the top two address bits.
    always_comb begin
        addr_start = req_addr;
        if (req_cmd == CMD_RCR)
            addr_start = {CR_SEL_RCR, req_addr[ADDR_W-3:0]};
        else if (req_cmd == CMD_BCR)
            addr_start = {CR_SEL_BCR, req_addr[ADDR_W-3:0]};
    end

    always_comb begin
        state_nxt = state;
        tmr_load  = 1'b0;
        tmr_val   = '0;
        case (state)
            ST_IDLE: begin
                if (accept && !zero_len) begin
                    tmr_load = 1'b1;
                    if (req_cmd == CMD_READ) begin
                        state_nxt = ST_ARD;
                        tmr_val   = TMR_W'(T_ASYNC - 1);
                    end else begin
                        state_nxt = ST_AWR;
                        tmr_val   = TMR_W'(T_WRITE - 1);
                    end
                end
            end
            ST_ARD, ST_PRD: begin
                if (capture) begin
                    tmr_load = 1'b1;
                    if (last_word) begin
                        state_nxt = ST_RECOV;
                        tmr_val   = TMR_W'(T_REC - 1);
                    end else if (page_wrap) begin
                        state_nxt = ST_ARD;
                        tmr_val   = TMR_W'(T_ASYNC - 1);
                    end else begin
                        state_nxt = ST_PRD;
                        tmr_val   = TMR_W'(T_PAGE - 1);
                    end
                end
            end
            ST_AWR: begin
                if (tmr_zero) begin
                    state_nxt = ST_RECOV;
                    tmr_load  = 1'b1;
                    tmr_val   = TMR_W'(T_REC - 1);
                end
            end
            ST_RECOV: begin
                if (tmr_zero)
                    state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_RECOV;
                tmr_load  = 1'b1;
                tmr_val   = TMR_W'(T_REC - 1);
            end
        endcase
    end

    cram_timer #(.W(TMR_W)) u_timer (
        .Clock    (Clock),
        .aReset   (aReset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .hold     (tmr_hold),
        .zero     (tmr_zero)
    );

    always_ff @(posedge Clock or posedge aReset) begin
        if (aReset) begin
            state     <= ST_IDLE;
            cmd_q     <= CMD_READ;
            cnt_q     <= '0;
            wdata_q   <= '0;
            cram_addr <= '0;
            rd_data   <= '0;
            rd_valid  <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state    <= state_nxt;
            rd_valid <= capture;
            done     <= ((state == ST_RECOV) && tmr_zero) || (accept && zero_len);
            err      <= accept && zero_len;
            if (accept) begin
                cmd_q   <= req_cmd;
                cnt_q   <= req_len;
                wdata_q <= wr_data;
                // A zero-length read never touches the bus, so the address is left alone.
                if (!zero_len)
                    cram_addr <= addr_start;
            end
            if (capture) begin
                rd_data <= cram_dq_in;
                cnt_q   <= cnt_q - LEN_W'(1);
                if (!last_word)
                    cram_addr <= addr_inc;
            end
        end
    end

    assign req_ready   = (state == ST_IDLE);
    assign busy        = (state != ST_IDLE);
    assign cram_ce_n   = !(rd_phase || state == ST_AWR);
    assign cram_oe_n   = !rd_phase;
    assign cram_we_n   = (state != ST_AWR);
    assign cram_cre    = (state == ST_AWR) && is_cfg_cmd(cmd_q);
    assign cram_dq_oe  = (state == ST_AWR) && (cmd_q == CMD_WRITE);
    assign cram_dq_out = wdata_q;

endmodule

// File: tb/tb_cram_page_ctrl.sv
// Directed bench for cram_page_ctrl; the memory model returns addr[15:0]^16'hA5A5
// so every captured word also proves which address was on the bus.
module tb_cram_page_ctrl;

    logic        Clock = 1'b0;
    logic        aReset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_cmd = 2'b00;
    logic [22:0] req_addr = '0;
    logic [7:0]  req_len = '0;
    logic [15:0] wr_data = '0;
    logic        rd_stall = 1'b0;
    logic        rd_valid;
    logic [15:0] rd_data;
    logic        done, err, busy;
    logic [22:0] cram_addr;
    logic        cram_ce_n, cram_oe_n, cram_we_n, cram_cre;
    logic [15:0] cram_dq_out;
    logic        cram_dq_oe;
    logic [15:0] cram_dq_in;

    int checks = 0;
    int failures = 0;

    int          vt[8];
    logic [15:0] vd[8];
    int          nv, done_t, err_at_done, ce_lo, we_lo, done_cnt;
    logic [22:0] addr_hold, addr0;
    logic        cre0, dqoe0;
    logic [15:0] dqout0;

    always #5 Clock = ~Clock;

    assign cram_dq_in = cram_addr[15:0] ^ 16'hA5A5;

    cram_page_ctrl dut (
        .Clock       (Clock),
        .aReset      (aReset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_cmd     (req_cmd),
        .req_addr    (req_addr),
        .req_len     (req_len),
        .wr_data     (wr_data),
        .rd_stall    (rd_stall),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .done        (done),
        .err         (err),
        .busy        (busy),
        .cram_addr   (cram_addr),
        .cram_ce_n   (cram_ce_n),
        .cram_oe_n   (cram_oe_n),
        .cram_we_n   (cram_we_n),
        .cram_cre    (cram_cre),
        .cram_dq_out (cram_dq_out),
        .cram_dq_oe  (cram_dq_oe),
        .cram_dq_in  (cram_dq_in)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // t=0 is the cycle right after the accepting edge; stall covers cycles [st_start, st_start+st_len).
    task automatic run_read(input logic [22:0] a, input logic [7:0] len,
                            input int st_start, input int st_len);
        nv = 0; done_t = -1; err_at_done = 0; ce_lo = 0; addr_hold = '0;
        req_cmd = 2'b00; req_addr = a; req_len = len; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        for (int t = 0; t < 80; t++) begin
            if (t > 0) tick();
            if (rd_valid && nv < 8) begin
                vt[nv] = t;
                vd[nv] = rd_data;
                nv++;
            end
            if (!cram_ce_n) ce_lo++;
            if (st_len > 0 && t == st_start + st_len) addr_hold = cram_addr;
            rd_stall = (st_len > 0 && t >= st_start && t < st_start + st_len);
            if (done) begin
                done_t = t;
                err_at_done = int'(err);
                break;
            end
        end
        rd_stall = 1'b0;
        chk("read_completes", done_t >= 0, 1);
    endtask

    task automatic run_write(input logic [1:0] cmd, input logic [22:0] a, input logic [15:0] d);
        done_t = -1; we_lo = 0;
        req_cmd = cmd; req_addr = a; wr_data = d; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        addr0 = cram_addr; cre0 = cram_cre; dqoe0 = cram_dq_oe; dqout0 = cram_dq_out;
        for (int t = 0; t < 40; t++) begin
            if (t > 0) tick();
            if (!cram_we_n) we_lo++;
            if (done) begin
                done_t = t;
                break;
            end
        end
        chk("write_completes", done_t >= 0, 1);
    endtask

    initial begin
        // Reset state
        tick(); tick();
        chk("rst_strobes", {cram_ce_n, cram_oe_n, cram_we_n, cram_cre, cram_dq_oe}, 5'b11100);
        chk("rst_flags", {rd_valid, done, err, busy}, 4'b0000);
        chk("rst_addr", cram_addr, 23'h0);
        chk("rst_rd_data", rd_data, 16'h0);
        chk("rst_dq_out", cram_dq_out, 16'h0);
        aReset = 1'b0;
        tick();
        chk("rst_ready", req_ready, 1'b1);

        // Four-word read crossing a page boundary at 0x10
        run_read(23'h00000E, 8'd4, 0, 0);
        chk("r1_nvalid", nv, 4);
        chk("r1_t0", vt[0], 7);
        chk("r1_t1", vt[1], 9);
        chk("r1_t2", vt[2], 16);
        chk("r1_t3", vt[3], 18);
        chk("r1_d0", vd[0], 16'hA5A5 ^ 16'h000E);
        chk("r1_d1", vd[1], 16'hA5A5 ^ 16'h000F);
        chk("r1_d2", vd[2], 16'hA5A5 ^ 16'h0010);
        chk("r1_d3", vd[3], 16'hA5A5 ^ 16'h0011);
        chk("r1_done_t", done_t, 19);
        chk("r1_err", err_at_done, 0);
        chk("r1_ce_lo", ce_lo, 18);
        tick();
        chk("r1_done_pulse", done, 1'b0);

        // Address wraps from the top to zero and restarts with an async access
        run_read(23'h7FFFFF, 8'd2, 0, 0);
        chk("r2_nvalid", nv, 2);
        chk("r2_t0", vt[0], 7);
        chk("r2_t1", vt[1], 14);
        chk("r2_d0", vd[0], 16'h5A5A);
        chk("r2_d1", vd[1], 16'hA5A5);
        chk("r2_done_t", done_t, 15);
        chk("r2_addr", cram_addr, 23'h000000);

        // Stall of five cycles at the first sample point
        run_read(23'h000100, 8'd3, 6, 5);
        chk("r3_nvalid", nv, 3);
        chk("r3_t0", vt[0], 12);
        chk("r3_t1", vt[1], 14);
        chk("r3_t2", vt[2], 16);
        chk("r3_d0", vd[0], 16'hA5A5 ^ 16'h0100);
        chk("r3_d2", vd[2], 16'hA5A5 ^ 16'h0102);
        chk("r3_addr_hold", addr_hold, 23'h000100);
        chk("r3_done_t", done_t, 17);
        chk("r3_ce_lo", ce_lo, 16);

        // Plain write
        run_write(2'b01, 23'h123456, 16'hBEEF);
        chk("w_addr", addr0, 23'h123456);
        chk("w_cre", cre0, 1'b0);
        chk("w_dqoe", dqoe0, 1'b1);
        chk("w_dqout", dqout0, 16'hBEEF);
        chk("w_we_lo", we_lo, 7);
        chk("w_done_t", done_t, 8);

        // BCR write
        run_write(2'b11, 23'h00A51F, 16'h1234);
        chk("bcr_addr", addr0, 23'h40A51F);
        chk("bcr_cre", cre0, 1'b1);
        chk("bcr_dqoe", dqoe0, 1'b0);
        chk("bcr_we_lo", we_lo, 7);
        chk("bcr_done_t", done_t, 8);

        // RCR write clears the select bits
        run_write(2'b10, 23'h7FFFFF, 16'h0000);
        chk("rcr_addr", addr0, 23'h1FFFFF);
        chk("rcr_cre", cre0, 1'b1);

        // Zero-length read
        run_read(23'h000055, 8'd0, 0, 0);
        chk("z_done_t", done_t, 0);
        chk("z_err", err_at_done, 1);
        chk("z_ce_lo", ce_lo, 0);
        chk("z_addr_kept", cram_addr, 23'h1FFFFF);
        tick();
        chk("z_pulse", {done, err}, 2'b00);

        // Request presented while busy is ignored, then reset lands in PRD
        req_cmd = 2'b00; req_addr = 23'h000020; req_len = 8'd4; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        tick(); tick();
        req_valid = 1'b1; req_cmd = 2'b01;
        chk("busy_ready", req_ready, 1'b0);
        tick();
        chk("busy_no_accept", {cram_we_n, cram_oe_n}, 2'b10);
        req_valid = 1'b0;
        repeat (4) tick();
        chk("prd_addr", cram_addr, 23'h000021);
        chk("prd_oe", cram_oe_n, 1'b0);
        aReset = 1'b1;
        #1;
        chk("arst_strobes", {cram_ce_n, cram_oe_n, cram_we_n, cram_cre, cram_dq_oe}, 5'b11100);
        chk("arst_flags", {rd_valid, done, busy}, 3'b000);
        tick();
        aReset = 1'b0;
        chk("arst_ready", req_ready, 1'b1);
        done_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (done) done_cnt++;
            tick();
        end
        chk("arst_no_done", done_cnt, 0);
        run_write(2'b01, 23'h000333, 16'h5555);
        chk("arst_new_req", done_t, 8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

endmodule

// File: doc/cram_page_ctrl.md
CRAM_PAGE_CTRL -- requirements
Module: cram_page_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 23: CRAM halfword address width.
REQ-002 SHALL have parameter DATA_W, default 16: CRAM data width.
REQ-003 SHALL have parameter PAGE_WORDS, default 16: page length; power of two, >=2.
REQ-004 SHALL have parameter LEN_W, default 8: request length width.
REQ-005 SHALL have parameters T_ASYNC=7, T_PAGE=2, T_WRITE=7, T_REC=1: access/recovery cycle counts, each >=1.
REQ-006 SHALL use reset aReset, asynchronous, active-high, and clock Clock.
REQ-007 SHALL have ports (name, direction, width, meaning):
- Clock  in  1  clock
- aReset  in  1  async reset
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE
- req_cmd  in  2  00 page read, 01 write, 10 RCR write, 11 BCR write
- req_addr  in  ADDR_W  start address, or register value for cfg writes
- req_len  in  LEN_W  halfwords to read; ignored for writes
- wr_data  in  DATA_W  write data
- rd_stall  in  1  downstream full
- rd_valid  out  1  one-cycle read strobe
- rd_data  out  DATA_W  read word
- done  out  1  one-cycle completion pulse
- err  out  1  with done: zero-length read
- busy  out  1  state != IDLE
- cram_addr  out  ADDR_W  address bus
- cram_ce_n, cram_oe_n, cram_we_n  out  1 each  strobes
- cram_cre  out  1  config-register enable
- cram_dq_out  out  DATA_W  write data
- cram_dq_oe  out  1  DQ drive enable
- cram_dq_in  in  DATA_W  read data

Function
REQ-008 SHALL accept a request on a clock edge with req_valid && req_ready, latching cmd, addr, len and wr_data.
REQ-009 SHALL implement states IDLE, ARD (async read), PRD (page read), AWR (write), RECOV; all other encodings SHALL go to RECOV.
REQ-010 SHALL, for a read with len>0, enter ARD: ce_n=0, oe_n=0, cram_addr=latched address, timer loaded T_ASYNC-1.
REQ-011 SHALL decrement the timer each cycle; in the cycle timer==0 with rd_stall=0, capture cram_dq_in into rd_data and assert rd_valid in the following cycle only.
REQ-012 SHALL hold timer at 0, address and strobes unchanged, and capture nothing while rd_stall=1 at timer==0.
REQ-013 SHALL after each capture: decrement remaining count; if it was 1, go to RECOV; else increment address modulo 2^ADDR_W, then go to ARD (timer T_ASYNC-1) if the new address's low log2(PAGE_WORDS) bits are zero, else PRD (timer T_PAGE-1); ce_n stays 0 throughout.
REQ-014 SHALL, for cmd 01/10/11, enter AWR for T_WRITE cycles: ce_n=0, we_n=0, oe_n=1, dq_oe=1, dq_out=wr_data; cram_cre=1 and dq_oe=0 for 10/11; cmd 10 forces cram_addr[ADDR_W-1:ADDR_W-2]=00, cmd 11 forces 10, lower bits from req_addr.
REQ-015 SHALL in RECOV drive ce_n=oe_n=we_n=1, cre=0, dq_oe=0 for T_REC cycles, then return to IDLE and pulse done in the first IDLE cycle.
REQ-016 SHALL, for a read with len==0, perform no CRAM access and pulse done and err in the cycle after acceptance.
REQ-017 SHALL keep req_ready=0 outside IDLE; requests presented then are not accepted.
REQ-018 SHALL drive, in IDLE, ce_n=oe_n=we_n=1, cre=0, dq_oe=0; cram_addr holds its last value.

Reset
REQ-019 SHALL on aReset immediately force state IDLE, timer/count 0, cram_addr 0, rd_data 0, rd_valid=done=err=busy=0, ce_n=oe_n=we_n=1, cre=0, dq_oe=0, dq_out 0.
REQ-020 SHALL on reset mid-access abandon the access with no done pulse; req_ready is 1 on the first cycle after release.

Structure
REQ-021 SHALL place cmd encodings, state encodings and CR-select constants in shared package cram_pkg.
REQ-022 SHALL implement the loadable down-counting access timer as sub-module cram_timer (parameter width; ports load, load_val, hold, zero).

Verification
REQ-023 Defaults, read addr 0x00000E len 4 -> words 0x0E (7 cyc), 0x0F (2), 0x10 (7, boundary), 0x11 (2); 4 rd_valid; done after 1 RECOV cycle.
REQ-024 Read addr 0x7FFFFF len 2 -> second word at 0x000000 via ARD (7 cycles).
REQ-025 Read len 3 with rd_stall high 5 cycles at first timer==0 -> first rd_valid delayed exactly 5 cycles, address held.
REQ-026 BCR write req_addr 0x00A51F -> 7 cycles we_n=0, cre=1, cram_addr[22:21]=10, dq_oe=0; then done.
REQ-027 Read len 0 -> no ce_n activity, done=err=1 one cycle after accept.
REQ-028 aReset asserted during PRD -> all strobes high same cycle, no done; new request accepted after release.
